// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU operation at a time over a valid/ready
// request handshake, holds the operands while the ALU settles, pulses
// read-enable, captures result and flags, and returns them over a
// valid/ready response handshake.
// Optional feature macro: ALU_SEQ_SUB_EN (two's-complement operand B and
// complement carry for opcode 111). Undefined: opcode 111 passes B through.
module alu_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             SEQ_clk,
  input  logic             SEQ_rst_n,
  input  logic             SEQ_req_valid,
  output logic             SEQ_req_ready,
  input  logic [2:0]       SEQ_req_op,
  input  logic [WIDTH-1:0] SEQ_req_a,
  input  logic [WIDTH-1:0] SEQ_req_b,
  output logic [WIDTH-1:0] SEQ_alu_input1,
  output logic [WIDTH-1:0] SEQ_alu_input2,
  output logic [2:0]       SEQ_alu_operation,
  output logic             SEQ_alu_read_enable,
  output logic             SEQ_alu_complement_carry,
  input  logic [WIDTH-1:0] SEQ_alu_result,
  input  logic [7:0]       SEQ_alu_flags,
  output logic             SEQ_rsp_valid,
  input  logic             SEQ_rsp_ready,
  output logic [WIDTH-1:0] SEQ_rsp_result,
  output logic [7:0]       SEQ_rsp_flags,
  output logic [2:0]       SEQ_rsp_op,
  output logic             SEQ_busy
);

  // A settle time of zero still needs one DRIVE cycle.
  localparam int unsigned SE = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CW = (SE > 1) ? $clog2(SE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] in1_q, in2_q, in2_d;
  logic [2:0]       op_q;
  logic             cc_q, cc_d;

  logic [WIDTH-1:0] res_q;
  logic [7:0]       flg_q;
  logic [2:0]       rop_q;

  logic             accept;

  assign accept = (state_q == S_IDLE) && SEQ_req_valid;

  // State register and settle counter.
  always_ff @(posedge SEQ_clk or negedge SEQ_rst_n) begin
    if (!SEQ_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and settle counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (SEQ_req_valid) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CW'(SE - 1)) begin
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (SEQ_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef ALU_SEQ_SUB_EN
  logic [WIDTH:0] neg_b;
  assign neg_b = {1'b0, ~SEQ_req_b} + (WIDTH + 1)'(1);

  // Operand B formation: negate B for subtraction, carry out of the increment.
  always_comb begin
    in2_d = SEQ_req_b;
    cc_d  = 1'b0;
    if (SEQ_req_op == 3'b111) begin
      {cc_d, in2_d} = neg_b;
    end
  end
`else
  // Operand B formation: B passes through for every opcode.
  always_comb begin
    in2_d = SEQ_req_b;
    cc_d  = 1'b0;
  end
`endif

  // ALU operand registers, loaded only at the accept edge.
  always_ff @(posedge SEQ_clk or negedge SEQ_rst_n) begin
    if (!SEQ_rst_n) begin
      in1_q <= '0;
      in2_q <= '0;
      op_q  <= '0;
      cc_q  <= 1'b0;
    end else if (accept) begin
      in1_q <= SEQ_req_a;
      in2_q <= in2_d;
      op_q  <= SEQ_req_op;
      cc_q  <= cc_d;
    end
  end

  // Response registers, loaded only at the closing edge of CAPTURE.
  always_ff @(posedge SEQ_clk or negedge SEQ_rst_n) begin
    if (!SEQ_rst_n) begin
      res_q <= '0;
      flg_q <= '0;
      rop_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      res_q <= SEQ_alu_result;
      flg_q <= SEQ_alu_flags;
      rop_q <= op_q;
    end
  end

  assign SEQ_req_ready            = (state_q == S_IDLE);
  assign SEQ_busy                 = (state_q != S_IDLE);
  assign SEQ_alu_read_enable      = (state_q == S_READ);
  assign SEQ_rsp_valid            = (state_q == S_RESP);
  assign SEQ_alu_input1           = in1_q;
  assign SEQ_alu_input2           = in2_q;
  assign SEQ_alu_operation        = op_q;
  assign SEQ_alu_complement_carry = cc_q;
  assign SEQ_rsp_result           = res_q;
  assign SEQ_rsp_flags            = flg_q;
  assign SEQ_rsp_op               = rop_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a small ALU model attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [7:0] in1, in2;
  logic [2:0] alu_op;
  logic       re, cc;
  logic [7:0] alu_res;
  logic [7:0] alu_flg;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic [7:0] rsp_flags;
  logic [2:0] rsp_op;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
    .SEQ_clk(clk), .SEQ_rst_n(rst_n),
    .SEQ_req_valid(req_valid), .SEQ_req_ready(req_ready),
    .SEQ_req_op(req_op), .SEQ_req_a(req_a), .SEQ_req_b(req_b),
    .SEQ_alu_input1(in1), .SEQ_alu_input2(in2),
    .SEQ_alu_operation(alu_op), .SEQ_alu_read_enable(re),
    .SEQ_alu_complement_carry(cc),
    .SEQ_alu_result(alu_res), .SEQ_alu_flags(alu_flg),
    .SEQ_rsp_valid(rsp_valid), .SEQ_rsp_ready(rsp_ready),
    .SEQ_rsp_result(rsp_result), .SEQ_rsp_flags(rsp_flags),
    .SEQ_rsp_op(rsp_op), .SEQ_busy(busy)
  );

  // ALU model: flags = {000, cc, parity, all-ones, zero, carry}.
  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, in1} + {1'b0, in2};
    alu_res = '0;
    case (alu_op)
      3'b000:  alu_res = sum[7:0];
      3'b001:  alu_res = in1 & in2;
      3'b010:  alu_res = in1 | in2;
      3'b011:  alu_res = ~(in1 & in2);
      3'b100:  alu_res = ~(in1 | in2);
      3'b101:  alu_res = in1 ^ in2;
      3'b110:  alu_res = ~(in1 ^ in2);
      default: alu_res = sum[7:0];
    endcase
    alu_flg = {3'b000, cc, ^alu_res, &alu_res, (alu_res == 8'h00),
               ((alu_op == 3'b000 || alu_op == 3'b111) ? sum[8] : 1'b0)};
  end

  // Present a request at posedge+1 and return 1 ns after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Bounded wait for rsp_valid; ok=0 on timeout.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, re, rsp_valid, cc} !== 5'b10000 ||
        {in1, in2, alu_op, rsp_result, rsp_flags, rsp_op} !== 38'h0) begin
      failures++;
      $display("FAIL reset_async: ready/busy/re/valid/cc=%b regs=%h required 10000 / 0",
               {req_ready, busy, re, rsp_valid, cc},
               {in1, in2, alu_op, rsp_result, rsp_flags, rsp_op});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: ready=%b busy=%b required 1 0", req_ready, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_ready: got %b required 1", req_ready);
    end
    issue(3'b000, 8'h0F, 8'h01);
    checks++;
    if (in1 !== 8'h0F || in2 !== 8'h01 || alu_op !== 3'b000 || cc !== 1'b0 ||
        busy !== 1'b1 || re !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL add_e0: in1=%h in2=%h op=%h cc=%b busy=%b re=%b rdy=%b required 0f 01 0 0 1 0 0",
               in1, in2, alu_op, cc, busy, re, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (re !== 1'b0) begin
      failures++;
      $display("FAIL add_re_e1: got %b required 0", re);
    end
    @(posedge clk); #1;
    checks++;
    if (re !== 1'b1) begin
      failures++;
      $display("FAIL add_re_e2: got %b required 1", re);
    end
    @(posedge clk); #1;
    checks++;
    if (re !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_e3: re=%b rsp_valid=%b required 0 0", re, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h10 || rsp_flags !== 8'h08 || rsp_op !== 3'b000) begin
      failures++;
      $display("FAIL add_e4: valid=%b result=%h flags=%h op=%h required 1 10 08 0",
               rsp_valid, rsp_result, rsp_flags, rsp_op);
    end
    complete();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL add_release: ready=%b valid=%b busy=%b required 1 0 0",
               req_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_nor_zero();
    bit ok;
    issue(3'b100, 8'hF0, 8'h0F);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 8'h00 || rsp_flags !== 8'h02 || rsp_op !== 3'b100) begin
      failures++;
      $display("FAIL nor_zero: seen=%b result=%h flags=%h op=%h required 1 00 02 4",
               ok, rsp_result, rsp_flags, rsp_op);
    end
    complete();
  endtask

`ifdef ALU_SEQ_SUB_EN
  task automatic test_sub();
    bit ok;
    issue(3'b111, 8'h05, 8'h03);
    checks++;
    if (in1 !== 8'h05 || in2 !== 8'hFD || cc !== 1'b0) begin
      failures++;
      $display("FAIL sub_nonzero_operands: in1=%h in2=%h cc=%b required 05 fd 0", in1, in2, cc);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 8'h02 || rsp_flags !== 8'h09) begin
      failures++;
      $display("FAIL sub_nonzero_rsp: seen=%b result=%h flags=%h required 1 02 09",
               ok, rsp_result, rsp_flags);
    end
    complete();
    @(posedge clk); #1;
    issue(3'b111, 8'h05, 8'h00);
    checks++;
    if (in2 !== 8'h00 || cc !== 1'b1) begin
      failures++;
      $display("FAIL sub_zero_operands: in2=%h cc=%b required 00 1", in2, cc);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 8'h05 || rsp_flags !== 8'h10) begin
      failures++;
      $display("FAIL sub_zero_rsp: seen=%b result=%h flags=%h required 1 05 10",
               ok, rsp_result, rsp_flags);
    end
    complete();
  endtask
`else
  task automatic test_sub_disabled();
    bit ok;
    bit bad;
    bad = 1'b0;
    issue(3'b111, 8'h05, 8'h03);
    for (int i = 0; i < 20; i++) begin
      if (in2 !== 8'h03 || cc !== 1'b0) bad = 1'b1;
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    wait_rsp(ok);
    checks++;
    if (bad || !ok || rsp_result !== 8'h08) begin
      failures++;
      $display("FAIL sub_disabled: operand_err=%b seen=%b result=%h required 0 1 08",
               bad, ok, rsp_result);
    end
    complete();
  endtask
`endif

  task automatic test_backpressure();
    bit ok;
    bit bad;
    bad = 1'b0;
    issue(3'b001, 8'hF0, 8'h3C);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 8'h30 || rsp_flags !== 8'h00) begin
      failures++;
      $display("FAIL bp_rsp: seen=%b result=%h flags=%h required 1 30 00", ok, rsp_result, rsp_flags);
    end
    req_valid = 1'b1;
    req_op = 3'b101;
    req_a = 8'hAA;
    req_b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h30 || req_ready !== 1'b0 ||
          in1 !== 8'hF0 || in2 !== 8'h3C || alu_op !== 3'b001) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: valid=%b result=%h ready=%b in1=%h in2=%h op=%h required 1 30 0 f0 3c 1",
               rsp_valid, rsp_result, req_ready, in1, in2, alu_op);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || in1 !== 8'hF0) begin
      failures++;
      $display("FAIL bp_release: ready=%b valid=%b in1=%h required 1 0 f0", req_ready, rsp_valid, in1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in1 !== 8'hAA || in2 !== 8'h0F || alu_op !== 3'b101) begin
      failures++;
      $display("FAIL bp_next_accept: busy=%b in1=%h in2=%h op=%h required 1 aa 0f 5",
               busy, in1, in2, alu_op);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 8'hA5) begin
      failures++;
      $display("FAIL bp_next_rsp: seen=%b result=%h required 1 a5", ok, rsp_result);
    end
    complete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    issue(3'b000, 8'h0F, 8'h01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (re !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_in_read: re=%b required 1", re);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, re, rsp_valid, cc} !== 5'b10000 ||
        {in1, in2, alu_op, rsp_result, rsp_flags, rsp_op} !== 38'h0) begin
      failures++;
      $display("FAIL rstmid_async: ready/busy/re/valid/cc=%b regs=%h required 10000 / 0",
               {req_ready, busy, re, rsp_valid, cc},
               {in1, in2, alu_op, rsp_result, rsp_flags, rsp_op});
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rstmid_no_rsp: stray activity after reset, required none");
    end
    issue(3'b000, 8'h01, 8'h01);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 8'h02 || rsp_flags !== 8'h08) begin
      failures++;
      $display("FAIL rstmid_recover: seen=%b result=%h flags=%h required 1 02 08",
               ok, rsp_result, rsp_flags);
    end
    complete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_nor_zero();
`ifdef ALU_SEQ_SUB_EN
    test_sub();
`else
    test_sub_disabled();
`endif
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
